// File: rtl/rv32_ctrl_pkg.sv
// rv32_ctrl_pkg: shared opcode, field-select, ALU and FSM encodings for the decode control pipe.
package rv32_ctrl_pkg;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_NOP    = 7'b0000000;
   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_M      = 7'b0000001;
   localparam logic [2:0] IMM_I = 3'd1;
   localparam logic [2:0] IMM_S = 3'd2;
   localparam logic [2:0] IMM_B = 3'd3;
   localparam logic [2:0] IMM_U = 3'd4;
   localparam logic [2:0] IMM_J = 3'd5;
   localparam logic [1:0] RWS_ALU = 2'd0;
   localparam logic [1:0] RWS_MEM = 2'd1;
   localparam logic [1:0] RWS_PC4 = 2'd2;
   localparam logic [1:0] RWS_IMM = 2'd3;
   localparam logic [2:0] BR_ALWAYS = 3'b010;
   typedef enum logic [1:0] {IDLE, HOLD, MULTI} state_t;
   // M-extension codes are 5'b10_f3 so the decoder can build them from funct3 directly
   typedef enum logic [4:0] {
      ALU_ADD = 5'd0, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND,
      ALU_MUL = 5'd16, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
   } alu_t;
   typedef struct packed {
      logic [4:0] alu;
      logic       rfw;
      logic [2:0] mmw;
      logic [3:0] mmr;
      logic [3:0] bc;
      logic [3:0] imm;
      logic       op1;
      logic       op2;
      logic [1:0] rws;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       ill;
   } ctrl_t;
   function automatic logic [4:0] alu_base(input logic [2:0] f3, input logic alt);
      return f3 == 3'd0 ? (alt ? ALU_SUB : ALU_ADD) :
             f3 == 3'd1 ? ALU_SLL :
             f3 == 3'd2 ? ALU_SLT :
             f3 == 3'd3 ? ALU_SLTU :
             f3 == 3'd4 ? ALU_XOR :
             f3 == 3'd5 ? (alt ? ALU_SRA : ALU_SRL) :
             f3 == 3'd6 ? ALU_OR : ALU_AND;
   endfunction
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational RV32I control decoder; RV32M_EXT_EN adds the M-extension ops
// (flagged mul_op/div_op), otherwise funct7 0000001 on OP is illegal.
module ctrl_decode
   import rv32_ctrl_pkg::*;
(
   input  logic [31:0] instr,
   output ctrl_t       ctrl,
   output logic        mul_op,
   output logic        div_op
);
   logic [6:0] opc;
   logic [2:0] f3;
   logic [6:0] f7;
   assign opc = instr[6:0];
   assign f3  = instr[14:12];
   assign f7  = instr[31:25];
   always_comb begin
      ctrl     = '0;
      mul_op   = 1'b0;
      div_op   = 1'b0;
      ctrl.rd  = instr[11:7];
      ctrl.rs1 = instr[19:15];
      ctrl.rs2 = instr[24:20];
      case (opc)
         OP_LUI: begin
            ctrl.rfw = 1'b1; ctrl.imm = {1'b0, IMM_U}; ctrl.op2 = 1'b1; ctrl.rws = RWS_IMM;
         end
         OP_AUIPC: begin
            ctrl.rfw = 1'b1; ctrl.imm = {1'b0, IMM_U}; ctrl.op1 = 1'b1; ctrl.op2 = 1'b1;
         end
         OP_JAL: begin
            ctrl.rfw = 1'b1; ctrl.imm = {1'b0, IMM_J}; ctrl.op1 = 1'b1; ctrl.op2 = 1'b1;
            ctrl.bc = {1'b1, BR_ALWAYS}; ctrl.rws = RWS_PC4;
         end
         OP_JALR: begin
            ctrl.rfw = 1'b1; ctrl.imm = {1'b0, IMM_I}; ctrl.op2 = 1'b1;
            ctrl.bc = {1'b1, BR_ALWAYS}; ctrl.rws = RWS_PC4; ctrl.ill = f3 != 3'd0;
         end
         OP_BRANCH: begin
            ctrl.imm = {f3[1], IMM_B}; ctrl.bc = {1'b1, f3};
            ctrl.alu = f3[1] ? ALU_SLTU : f3[2] ? ALU_SLT : ALU_SUB;
            ctrl.ill = f3[2:1] == 2'b01;
         end
         OP_LOAD: begin
            ctrl.rfw = 1'b1; ctrl.imm = {f3[2], IMM_I}; ctrl.op2 = 1'b1;
            ctrl.mmr = {1'b1, f3}; ctrl.rws = RWS_MEM;
            ctrl.ill = f3 == 3'd3 || f3[2:1] == 2'b11;
         end
         OP_STORE: begin
            ctrl.imm = {1'b0, IMM_S}; ctrl.op2 = 1'b1; ctrl.mmw = {1'b1, f3[1:0]};
            ctrl.ill = f3 > 3'd2;
         end
         OP_IMM: begin
            ctrl.rfw = 1'b1; ctrl.imm = {f3 == 3'd3, IMM_I}; ctrl.op2 = 1'b1;
            ctrl.alu = alu_base(f3, f3 == 3'd5 && f7[5]);
            ctrl.ill = (f3 == 3'd1 && f7 != F7_BASE) || (f3 == 3'd5 && f7 != F7_BASE && f7 != F7_ALT);
         end
         OP_REG: begin
            ctrl.rfw = 1'b1;
            ctrl.alu = alu_base(f3, f7[5]);
            ctrl.ill = !(f7 == F7_BASE || (f7 == F7_ALT && (f3 == 3'd0 || f3 == 3'd5)));
            if (f7 == F7_M) begin
`ifdef RV32M_EXT_EN
               ctrl.ill = 1'b0; ctrl.alu = {2'b10, f3}; mul_op = ~f3[2]; div_op = f3[2];
`else
               ctrl.ill = 1'b1;
`endif
            end
         end
         OP_NOP: ctrl.ill = |instr[31:7];
         default: ctrl.ill = 1'b1;
      endcase
      // illegal words still issue, but must not write, access memory or redirect
      if (ctrl.ill) begin
         ctrl.rfw = 1'b0; ctrl.mmw = '0; ctrl.mmr = '0; ctrl.bc = '0; mul_op = 1'b0; div_op = 1'b0;
      end
   end
endmodule

// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe: registered decode stage with valid/ready handshake and a multi-cycle
// occupancy counter for M-extension ops (reachable only when RV32M_EXT_EN is defined).
module decode_ctrl_pipe
   import rv32_ctrl_pkg::*;
#(
   parameter int MUL_CYCLES = 1,
   parameter int DIV_CYCLES = 32
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [31:0] INSTRUCTION,
   input  logic        IN_VALID,
   output logic        IN_READY,
   input  logic        FLUSH,
   output logic        OUT_VALID,
   input  logic        OUT_READY,
   output logic [4:0]  alu_signal,
   output logic        reg_file_write,
   output logic [2:0]  main_mem_write,
   output logic [3:0]  main_mem_read,
   output logic [3:0]  branch_control,
   output logic [3:0]  immediate_select,
   output logic        oparand_1_select,
   output logic        oparand_2_select,
   output logic [1:0]  reg_write_select,
   output logic [4:0]  rd_addr,
   output logic [4:0]  rs1_addr,
   output logic [4:0]  rs2_addr,
   output logic        illegal,
   output logic        busy
);
   localparam logic [5:0] MUL_OCC = 6'(MUL_CYCLES - 1);
   localparam logic [5:0] DIV_OCC = 6'(DIV_CYCLES - 1);
   ctrl_t      dec, bundle;
   logic       dec_mul, dec_div;
   state_t     state, state_nx;
   logic [5:0] cnt, cnt_nx, occ;
   logic       multi, accept, handshake;
   ctrl_decode u_decode (.instr(INSTRUCTION), .ctrl(dec), .mul_op(dec_mul), .div_op(dec_div));
   assign OUT_VALID = state == HOLD;
   assign busy      = state == MULTI;
   // a held multi-cycle bundle blocks accept in its handshake cycle so MULTI starts clean
   assign IN_READY  = state != MULTI && (!OUT_VALID || (OUT_READY && !multi));
   assign accept    = IN_VALID && IN_READY;
   assign handshake = OUT_VALID && OUT_READY;
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      if (FLUSH) begin
         state_nx = IDLE;
         cnt_nx   = '0;
      end else if (state == MULTI) begin
         state_nx = cnt <= 6'd1 ? IDLE : MULTI;
         cnt_nx   = cnt - 6'(cnt != '0);
      end else if (accept) begin
         state_nx = HOLD;
      end else if (handshake) begin
         state_nx = multi ? MULTI : IDLE;
         cnt_nx   = multi ? occ : '0;
      end
   end
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state  <= IDLE;
         cnt    <= '0;
         bundle <= '0;
         multi  <= 1'b0;
         occ    <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (accept && !FLUSH) begin
            bundle <= dec;
            multi  <= dec_div || (dec_mul && MUL_CYCLES > 1);
            occ    <= dec_div ? DIV_OCC : MUL_OCC;
         end
      end
   end
   assign alu_signal       = bundle.alu;
   assign reg_file_write   = bundle.rfw;
   assign main_mem_write   = bundle.mmw;
   assign main_mem_read    = bundle.mmr;
   assign branch_control   = bundle.bc;
   assign immediate_select = bundle.imm;
   assign oparand_1_select = bundle.op1;
   assign oparand_2_select = bundle.op2;
   assign reg_write_select = bundle.rws;
   assign rd_addr          = bundle.rd;
   assign rs1_addr         = bundle.rs1;
   assign rs2_addr         = bundle.rs2;
   assign illegal          = bundle.ill;
endmodule
